// File: rtl/vga_timing_pkg.sv
// Shared coordinate/sync types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } sync_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Both sync pulses are active low in the 640x480 mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam sync_t SYNC_IDLE = '{hs: !SYNC_ACTIVE, vs: !SYNC_ACTIVE, bl: 1'b0};

  function automatic sync_t sync_decode(
    input coord_t x,
    input coord_t y,
    input coord_t h_act,
    input coord_t hs_lo,
    input coord_t hs_hi,
    input coord_t v_act,
    input coord_t vs_lo,
    input coord_t vs_hi
  );
    sync_t s;
    s.hs = ((x >= hs_lo) && (x < hs_hi)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    s.vs = ((y >= vs_lo) && (y < vs_hi)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    s.bl = (x < h_act) && (y < v_act);
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// PIPE_DLY-deep shift register for the {hsync, vsync, blank_b} triple; reset loads the idle pattern.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int PIPE_DLY = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  sync_t i_raw,
  output sync_t o_dly
);

  generate
    if (PIPE_DLY == 0) begin : g_pass
      assign o_dly = i_raw;
    end else begin : g_pipe
      sync_t r_stage [PIPE_DLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            r_stage[i] <= SYNC_IDLE;
          end
        end else if (i_en) begin
          r_stage[0] <= i_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_dly = r_stage[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counter with sync/blank decode delayed to line up with frame-RAM colour data.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t x,
  output coord_t y,
  output logic   hsync,
  output logic   vsync,
  output logic   blank_b,
  output logic   sync_b,
  output logic   frame_start,
  output logic   line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // Zero delay still uses one register, fed from the next count, so outputs never glitch.
  localparam int DLY_DEPTH = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  generate
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_pipe_dly
      $error("vga_timing_gen: PIPE_DLY must be in 0..4");
    end
  endgenerate

  coord_t r_x;
  coord_t r_y;
  coord_t w_x_nxt;
  coord_t w_y_nxt;
  coord_t w_dec_x;
  coord_t w_dec_y;
  sync_t  w_raw;
  sync_t  w_dly;
  logic   w_line;

  always_comb begin
    w_x_nxt = coord_t'(r_x + 10'd1);
    w_y_nxt = r_y;
    if (r_x == X_LAST) begin
      w_x_nxt = '0;
      w_y_nxt = (r_y == Y_LAST) ? '0 : coord_t'(r_y + 10'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (en) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  assign w_dec_x = (PIPE_DLY == 0) ? w_x_nxt : r_x;
  assign w_dec_y = (PIPE_DLY == 0) ? w_y_nxt : r_y;
  assign w_raw   = sync_decode(w_dec_x, w_dec_y, H_ACT, HS_LO, HS_HI, V_ACT, VS_LO, VS_HI);

  vga_sync_delay #(
    .PIPE_DLY (DLY_DEPTH)
  ) u_sync_delay (
    .clk   (clk),
    .rst   (rst),
    .i_en  (en),
    .i_raw (w_raw),
    .o_dly (w_dly)
  );

  assign w_line = en && !rst && (r_x == '0);

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = w_dly.hs;
  assign vsync       = w_dly.vs;
  assign blank_b     = w_dly.bl;
  assign sync_b      = 1'b0;
  assign line_start  = w_line;
  assign frame_start = w_line && (r_y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: four vga_timing_gen instances (full and reduced geometry, PIPE_DLY 0/2) against a behavioural scoreboard.
module tb_vga_timing_gen;

  localparam int NI = 4;
  localparam int HA [NI] = '{640, 640, 20, 20};
  localparam int HF [NI] = '{16, 16, 4, 4};
  localparam int HS [NI] = '{96, 96, 6, 6};
  localparam int HB [NI] = '{48, 48, 10, 10};
  localparam int VA [NI] = '{480, 480, 15, 15};
  localparam int VF [NI] = '{10, 10, 2, 2};
  localparam int VS [NI] = '{2, 2, 2, 2};
  localparam int VB [NI] = '{33, 33, 5, 5};
  localparam int PD [NI] = '{0, 2, 2, 0};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs;
    logic vs;
    logic bl;
    logic sb;
    logic ls;
    logic fs;
  } obs_t;

  typedef struct {
    int   inst;
    obs_t o;
  } exp_t;

  typedef struct {
    logic r;
    logic e;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic bl;
    logic ls;
    logic fs;
  } vec_t;

  logic clk;
  logic rst;
  logic en;
  logic [9:0] dx [NI];
  logic [9:0] dy [NI];
  logic dhs [NI];
  logic dvs [NI];
  logic dbl [NI];
  logic dsb [NI];
  logic dfs [NI];
  logic dls [NI];

  int   errors = 0;
  int   checks = 0;
  int   mx [NI];
  int   my [NI];
  int   nen [NI];
  obs_t s_obs [NI];
  obs_t p_obs [NI];
  exp_t sbq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE (HA[gi]), .H_FP (HF[gi]), .H_SYNC (HS[gi]), .H_BP (HB[gi]),
      .V_ACTIVE (VA[gi]), .V_FP (VF[gi]), .V_SYNC (VS[gi]), .V_BP (VB[gi]),
      .PIPE_DLY (PD[gi])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .x           (dx[gi]),
      .y           (dy[gi]),
      .hsync       (dhs[gi]),
      .vsync       (dvs[gi]),
      .blank_b     (dbl[gi]),
      .sync_b      (dsb[gi]),
      .frame_start (dfs[gi]),
      .line_start  (dls[gi])
    );
  end

  // Outputs show the raw decode of the count PIPE_DLY enabled edges back, idle until that much history exists.
  function automatic obs_t model_expect(int i, logic r, logic e);
    obs_t o;
    int ht = HA[i] + HF[i] + HS[i] + HB[i];
    int vt = VA[i] + VF[i] + VS[i] + VB[i];
    int need = (PD[i] == 0) ? 1 : PD[i];
    int pos;
    int px;
    int py;
    o.x  = 10'(mx[i]);
    o.y  = 10'(my[i]);
    o.sb = 1'b0;
    o.ls = e && !r && (mx[i] == 0);
    o.fs = o.ls && (my[i] == 0);
    if (nen[i] < need) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.bl = 1'b0;
    end else begin
      pos = my[i] * ht + mx[i] - PD[i];
      if (pos < 0) pos += ht * vt;
      px = pos % ht;
      py = pos / ht;
      o.hs = !((px >= HA[i] + HF[i]) && (px < HA[i] + HF[i] + HS[i]));
      o.vs = !((py >= VA[i] + VF[i]) && (py < VA[i] + VF[i] + VS[i]));
      o.bl = (px < HA[i]) && (py < VA[i]);
    end
    return o;
  endfunction

  function automatic void model_update(int i, logic r, logic e);
    int ht = HA[i] + HF[i] + HS[i] + HB[i];
    int vt = VA[i] + VF[i] + VS[i] + VB[i];
    if (r) begin
      mx[i] = 0;
      my[i] = 0;
      nen[i] = 0;
    end else if (e) begin
      if (nen[i] < 8) nen[i]++;
      if (mx[i] == ht - 1) begin
        mx[i] = 0;
        my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
      end else begin
        mx[i]++;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, queue expectations, sample 1 ns later, compare, then advance one clock.
  task automatic step(input logic r, input logic e);
    exp_t ex;
    obs_t got;
    rst = r;
    en  = e;
    for (int i = 0; i < NI; i++) sbq.push_back('{i, model_expect(i, r, e)});
    #1;
    p_obs = s_obs;
    for (int i = 0; i < NI; i++) begin
      s_obs[i] = '{x: dx[i], y: dy[i], hs: dhs[i], vs: dvs[i], bl: dbl[i],
                   sb: dsb[i], ls: dls[i], fs: dfs[i]};
    end
    while (sbq.size() > 0) begin
      ex  = sbq.pop_front();
      got = s_obs[ex.inst];
      checks++;
      if (got != ex.o) begin
        errors++;
        $display("FAIL sb inst%0d t=%0t got x=%0d y=%0d hs=%0b vs=%0b bl=%0b sb=%0b ls=%0b fs=%0b want x=%0d y=%0d hs=%0b vs=%0b bl=%0b sb=%0b ls=%0b fs=%0b",
                 ex.inst, $time, got.x, got.y, got.hs, got.vs, got.bl, got.sb, got.ls, got.fs,
                 ex.o.x, ex.o.y, ex.o.hs, ex.o.vs, ex.o.bl, ex.o.sb, ex.o.ls, ex.o.fs);
      end
    end
    for (int i = 0; i < NI; i++) model_update(i, r, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl [10];
    int ev_hs_fall0, ev_hs_rise0, ev_bl_fall0, ev_wrap_py, ev_wrap_sy, n_ls0;
    int ev_hs_fall1, ev_hs_rise1, ev_bl_fall1, ev_bl_rise1_x, ev_bl_rise1_y;
    int fs_cyc [8];
    int nfs, vlow, blh, wrap_px, wrap_py, vs_fall3_x, vs_fall3_y, vs_fall2_x;
    bit found;

    // Reset, then enable toggling; expectations are for the full-size PIPE_DLY=0 instance.
    tbl[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) model_update(i, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].r, tbl[k].e);
      $display("vec %0d: rst=%0b en=%0b x=%0d y=%0d hs=%0b vs=%0b bl=%0b ls=%0b fs=%0b",
               k, tbl[k].r, tbl[k].e, s_obs[0].x, s_obs[0].y, s_obs[0].hs, s_obs[0].vs,
               s_obs[0].bl, s_obs[0].ls, s_obs[0].fs);
      check("tbl x", int'(s_obs[0].x), tbl[k].x);
      check("tbl y", int'(s_obs[0].y), tbl[k].y);
      check("tbl hsync", int'(s_obs[0].hs), int'(tbl[k].hs));
      check("tbl vsync", int'(s_obs[0].vs), int'(tbl[k].vs));
      check("tbl blank_b", int'(s_obs[0].bl), int'(tbl[k].bl));
      check("tbl sync_b", int'(s_obs[0].sb), 0);
      check("tbl line_start", int'(s_obs[0].ls), int'(tbl[k].ls));
      check("tbl frame_start", int'(s_obs[0].fs), int'(tbl[k].fs));
    end

    // Line timing on the full-size instances.
    ev_hs_fall0 = -1; ev_hs_rise0 = -1; ev_bl_fall0 = -1; ev_wrap_py = -1; ev_wrap_sy = -1;
    ev_hs_fall1 = -1; ev_hs_rise1 = -1; ev_bl_fall1 = -1; ev_bl_rise1_x = -1; ev_bl_rise1_y = -1;
    n_ls0 = 0;
    for (int k = 0; k < 1700; k++) begin
      step(1'b0, 1'b1);
      if (s_obs[0].ls) n_ls0++;
      if (ev_hs_fall0 < 0 && p_obs[0].hs && !s_obs[0].hs) ev_hs_fall0 = int'(s_obs[0].x);
      if (ev_hs_rise0 < 0 && !p_obs[0].hs && s_obs[0].hs) ev_hs_rise0 = int'(s_obs[0].x);
      if (ev_bl_fall0 < 0 && p_obs[0].bl && !s_obs[0].bl) ev_bl_fall0 = int'(s_obs[0].x);
      if (ev_wrap_py < 0 && p_obs[0].x == 10'd799 && s_obs[0].x == 10'd0) begin
        ev_wrap_py = int'(p_obs[0].y);
        ev_wrap_sy = int'(s_obs[0].y);
      end
      if (ev_hs_fall1 < 0 && p_obs[1].hs && !s_obs[1].hs) ev_hs_fall1 = int'(s_obs[1].x);
      if (ev_hs_rise1 < 0 && !p_obs[1].hs && s_obs[1].hs) ev_hs_rise1 = int'(s_obs[1].x);
      if (ev_bl_fall1 < 0 && p_obs[1].bl && !s_obs[1].bl) ev_bl_fall1 = int'(s_obs[1].x);
      if (ev_bl_rise1_x < 0 && !p_obs[1].bl && s_obs[1].bl) begin
        ev_bl_rise1_x = int'(s_obs[1].x);
        ev_bl_rise1_y = int'(s_obs[1].y);
      end
    end
    check("hsync fall x (dly0)", ev_hs_fall0, 656);
    check("hsync rise x (dly0)", ev_hs_rise0, 752);
    check("blank_b fall x (dly0)", ev_bl_fall0, 640);
    check("wrap y before", ev_wrap_py, 0);
    check("wrap y after", ev_wrap_sy, 1);
    check("line_start count", n_ls0, 2);
    check("hsync fall x (dly2)", ev_hs_fall1, 658);
    check("hsync rise x (dly2)", ev_hs_rise1, 754);
    check("blank_b fall x (dly2)", ev_bl_fall1, 642);
    check("blank_b rise x (dly2)", ev_bl_rise1_x, 2);
    check("blank_b rise y (dly2)", ev_bl_rise1_y, 1);

    // Frame timing on the reduced 40x24 geometry (960 cycles per frame).
    step(1'b1, 1'b1);
    nfs = 0; vlow = 0; blh = 0; wrap_px = -1; wrap_py = -1;
    vs_fall3_x = -1; vs_fall3_y = -1; vs_fall2_x = -1;
    for (int c = 0; c < 2890; c++) begin
      step(1'b0, 1'b1);
      if (s_obs[3].fs) begin
        if (nfs < 8) fs_cyc[nfs] = c;
        nfs++;
        if (nfs == 2) begin
          wrap_px = int'(p_obs[3].x);
          wrap_py = int'(p_obs[3].y);
        end
      end
      if (nfs == 2) begin
        if (!s_obs[3].vs) vlow++;
        if (s_obs[3].bl) blh++;
      end
      if (vs_fall3_x < 0 && p_obs[3].vs && !s_obs[3].vs) begin
        vs_fall3_x = int'(s_obs[3].x);
        vs_fall3_y = int'(s_obs[3].y);
      end
      if (vs_fall2_x < 0 && p_obs[2].vs && !s_obs[2].vs) vs_fall2_x = int'(s_obs[2].x);
    end
    check("frame_start count", nfs, 4);
    check("frame period 1", (nfs >= 2) ? fs_cyc[1] - fs_cyc[0] : -1, 960);
    check("frame period 2", (nfs >= 3) ? fs_cyc[2] - fs_cyc[1] : -1, 960);
    check("frame wrap prev x", wrap_px, 39);
    check("frame wrap prev y", wrap_py, 23);
    check("vsync low cycles", vlow, 80);
    check("blank_b high cycles", blh, 300);
    check("vsync fall y (dly0)", vs_fall3_y, 17);
    check("vsync fall x (dly0)", vs_fall3_x, 0);
    check("vsync fall x (dly2)", vs_fall2_x, 2);

    // Mid-frame reset on the reduced PIPE_DLY=2 instance, while stale visible data sits in the delay line.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step(1'b0, 1'b1);
      if (s_obs[2].x == 10'd5 && s_obs[2].y == 10'd10) found = 1'b1;
    end
    check("find (5,10) within budget", int'(found), 1);
    step(1'b1, 1'b1);
    check("pre-reset blank_b", int'(s_obs[2].bl), 1);
    step(1'b0, 1'b1);
    check("post-reset x", int'(s_obs[2].x), 0);
    check("post-reset y", int'(s_obs[2].y), 0);
    check("post-reset hsync", int'(s_obs[2].hs), 1);
    check("post-reset blank_b c0", int'(s_obs[2].bl), 0);
    step(1'b0, 1'b1);
    check("post-reset blank_b c1", int'(s_obs[2].bl), 0);
    step(1'b0, 1'b1);
    check("post-reset x c2", int'(s_obs[2].x), 2);
    check("post-reset blank_b c2", int'(s_obs[2].bl), 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("hold x with en=0", int'(s_obs[2].x), 3);
    check("hold line_start with en=0", int'(s_obs[2].ls), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
